vdp_vram_arbiter: RTL and testbench

Shares the single VRAM port of the SDRAM controller among four VDP requesters: screen fetch, sprite fetch, command engine and the CPU I/O port (port #0 VRAM read/write). It grants one transaction at a time, forwards it downstream, and routes read data back to the requester that issued it. Screen fetch always wins. Sprite fetch comes next. Command engine and CPU alternate round-robin. The CPU has a starvation guard so that VRAM writes through port #0 complete within a bounded time.

---
 rtl/vdp_vram_arbiter.sv | 150 +++++++++++++++
 tb/tb_vdp_vram_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_vram_arbiter.sv
// Four-way VRAM port arbiter: screen > promoted CPU > sprite > (command <-> CPU round-robin).
// One transaction in flight; read data is steered back to the requester that issued it.
module vdp_vram_arbiter #(
  parameter int unsigned CPU_MAX_WAIT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scr_valid,
  input  logic [16:0] scr_address,
  output logic        scr_ready,
  output logic        scr_rdata_en,
  input  logic        spr_valid,
  input  logic [16:0] spr_address,
  output logic        spr_ready,
  output logic        spr_rdata_en,
  input  logic        cmd_valid,
  input  logic [16:0] cmd_address,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_wdata,
  output logic        cmd_ready,
  output logic        cmd_rdata_en,
  input  logic        cpu_valid,
  input  logic [16:0] cpu_address,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_rdata_en,
  output logic [31:0] rdata,
  output logic        vram_valid,
  input  logic        vram_ready,
  output logic [16:0] vram_address,
  output logic        vram_write,
  output logic [7:0]  vram_wdata,
  input  logic [31:0] vram_rdata,
  input  logic        vram_rdata_en
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_DATA} state_t;
  typedef enum logic [1:0] {G_SCR = 2'd0, G_SPR = 2'd1, G_CMD = 2'd2, G_CPU = 2'd3} grant_t;

  state_t              state;
  grant_t              grant;
  grant_t              winner;
  logic                rr_last_cpu;
  logic [WAIT_W-1:0]   cpu_wait;
  logic                any_valid;
  logic                cpu_promoted;
  logic                cpu_granted;
  logic [16:0]         sel_address;
  logic                sel_write;
  logic [7:0]          sel_wdata;
  logic                issue_ack;
  logic                data_ack;

  // Winner selection, only acted upon in IDLE
  always_comb begin
    any_valid    = scr_valid | spr_valid | cmd_valid | cpu_valid;
    cpu_promoted = cpu_valid && (cpu_wait == WAIT_MAX);
    winner       = G_SCR;
    if (scr_valid)                   winner = G_SCR;
    else if (cpu_promoted)           winner = G_CPU;
    else if (spr_valid)              winner = G_SPR;
    else if (cmd_valid && cpu_valid) winner = rr_last_cpu ? G_CMD : G_CPU;
    else if (cmd_valid)              winner = G_CMD;
    else if (cpu_valid)              winner = G_CPU;
  end

  // Fetch requesters are read-only, so their write/wdata are tied off
  always_comb begin
    sel_address = scr_address;
    sel_write   = 1'b0;
    sel_wdata   = 8'h00;
    case (winner)
      G_SPR: sel_address = spr_address;
      G_CMD: begin
        sel_address = cmd_address;
        sel_write   = cmd_write;
        sel_wdata   = cmd_wdata;
      end
      G_CPU: begin
        sel_address = cpu_address;
        sel_write   = cpu_write;
        sel_wdata   = cpu_wdata;
      end
      default: sel_address = scr_address;
    endcase
  end

  assign cpu_granted = (state == ST_IDLE) ? (any_valid && (winner == G_CPU))
                                          : (grant == G_CPU);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      grant        <= G_SCR;
      rr_last_cpu  <= 1'b1;
      cpu_wait     <= '0;
      vram_valid   <= 1'b0;
      vram_address <= '0;
      vram_write   <= 1'b0;
      vram_wdata   <= '0;
    end else begin
      if (!cpu_valid || cpu_granted) cpu_wait <= '0;
      else if (cpu_wait != WAIT_MAX) cpu_wait <= cpu_wait + WAIT_W'(1);

      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant        <= winner;
            vram_valid   <= 1'b1;
            vram_address <= sel_address;
            vram_write   <= sel_write;
            vram_wdata   <= sel_wdata;
            if (winner == G_CMD) rr_last_cpu <= 1'b0;
            if (winner == G_CPU) rr_last_cpu <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (vram_ready) begin
            vram_valid <= 1'b0;
            state      <= vram_write ? ST_IDLE : ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (vram_rdata_en) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake pulses are suppressed while reset is high so a dropped transaction never completes
  assign issue_ack = !reset && (state == ST_ISSUE) && vram_ready;
  assign data_ack  = !reset && (state == ST_WAIT_DATA) && vram_rdata_en;

  assign scr_ready    = issue_ack && (grant == G_SCR);
  assign spr_ready    = issue_ack && (grant == G_SPR);
  assign cmd_ready    = issue_ack && (grant == G_CMD);
  assign cpu_ready    = issue_ack && (grant == G_CPU);
  assign scr_rdata_en = data_ack && (grant == G_SCR);
  assign spr_rdata_en = data_ack && (grant == G_SPR);
  assign cmd_rdata_en = data_ack && (grant == G_CMD);
  assign cpu_rdata_en = data_ack && (grant == G_CPU);
  assign rdata        = data_ack ? vram_rdata : 32'h0;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Bench for vdp_vram_arbiter: transaction-level reference model, directed scenarios, random traffic.
module tb_vdp_vram_arbiter;

  localparam int MAXW = 32;

  bit          clk;
  logic        reset;
  logic [3:0]  req_v;
  logic [16:0] req_a [4];
  logic [3:0]  req_w;
  logic [7:0]  req_d [4];
  logic        vram_ready, vram_rdata_en;
  logic [31:0] vram_rdata;

  logic        scr_ready, spr_ready, cmd_ready, cpu_ready;
  logic        scr_rdata_en, spr_rdata_en, cmd_rdata_en, cpu_rdata_en;
  logic [31:0] rdata;
  logic        vram_valid, vram_write;
  logic [16:0] vram_address;
  logic [7:0]  vram_wdata;
  logic [3:0]  dut_ready, dut_rden;

  always #5 clk = ~clk;

  vdp_vram_arbiter #(.CPU_MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .scr_valid(req_v[0]), .scr_address(req_a[0]), .scr_ready(scr_ready), .scr_rdata_en(scr_rdata_en),
    .spr_valid(req_v[1]), .spr_address(req_a[1]), .spr_ready(spr_ready), .spr_rdata_en(spr_rdata_en),
    .cmd_valid(req_v[2]), .cmd_address(req_a[2]), .cmd_write(req_w[2]), .cmd_wdata(req_d[2]),
    .cmd_ready(cmd_ready), .cmd_rdata_en(cmd_rdata_en),
    .cpu_valid(req_v[3]), .cpu_address(req_a[3]), .cpu_write(req_w[3]), .cpu_wdata(req_d[3]),
    .cpu_ready(cpu_ready), .cpu_rdata_en(cpu_rdata_en),
    .rdata(rdata),
    .vram_valid(vram_valid), .vram_ready(vram_ready), .vram_address(vram_address),
    .vram_write(vram_write), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .vram_rdata_en(vram_rdata_en)
  );

  assign dut_ready = {cpu_ready, cmd_ready, spr_ready, scr_ready};
  assign dut_rden  = {cpu_rdata_en, cmd_rdata_en, spr_rdata_en, scr_rdata_en};

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the port, whether the downstream took it, CPU wait age, RR memory
  bit armed   = 0;
  bit m_busy  = 0;
  bit m_acc   = 0;
  int m_owner = 0;
  int m_wait  = 0;
  bit m_rr_cpu = 1;
  bit m_fresh = 1;
  bit acc_read_now = 0;
  int m_win;
  bit m_cpu_g;

  // Bench-side stimulus knobs
  bit [3:0]    got_ready = '0;
  bit [3:0]    persist   = '0;
  bit          rnd_req   = 0;
  bit          ds_rand   = 0;
  int          lat       = 3;
  int          pend      = 0;
  logic [31:0] next_val  = 32'h11111111;

  int          ready_log[$];
  int          rd_owner[$];
  logic [31:0] rd_val[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick();
    if (req_v[0]) return 0;
    if (req_v[3] && m_wait == MAXW) return 3;
    if (req_v[1]) return 1;
    if (req_v[2] && req_v[3]) return m_rr_cpu ? 2 : 3;
    if (req_v[2]) return 2;
    return 3;
  endfunction

  always @(posedge clk) begin
    acc_read_now = 0;
    if (reset) begin
      armed = 1; m_busy = 0; m_acc = 0; m_wait = 0; m_rr_cpu = 1; m_fresh = 1;
    end else begin
      m_cpu_g = 0;
      if (!m_busy) begin
        if (req_v != 4'b0) begin
          m_win   = pick();
          m_busy  = 1; m_acc = 0; m_owner = m_win; m_fresh = 0;
          m_cpu_g = (m_win == 3);
          if (m_win == 2) m_rr_cpu = 0;
          if (m_win == 3) m_rr_cpu = 1;
        end
      end else begin
        m_cpu_g = (m_owner == 3);
        if (!m_acc) begin
          if (vram_ready) begin
            if (m_owner >= 2 && req_w[m_owner]) m_busy = 0;
            else begin m_acc = 1; acc_read_now = 1; end
          end
        end else if (vram_rdata_en) m_busy = 0;
      end
      if (!req_v[3] || m_cpu_g) m_wait = 0;
      else if (m_wait < MAXW) m_wait++;
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (armed) begin
      bit exp_v, any_rd;
      bit [3:0] exp_rdy, exp_rd;
      exp_v = m_busy && !m_acc;
      for (int x = 0; x < 4; x++) begin
        exp_rdy[x] = !reset && m_busy && !m_acc && vram_ready && (m_owner == x);
        exp_rd[x]  = !reset && m_busy && m_acc && vram_rdata_en && (m_owner == x);
      end
      any_rd = |exp_rd;
      chk("vram_valid", 32'(vram_valid), 32'(exp_v));
      chk("x_ready", 32'(dut_ready), 32'(exp_rdy));
      chk("x_rdata_en", 32'(dut_rden), 32'(exp_rd));
      chk("rdata", rdata, any_rd ? vram_rdata : 32'h0);
      if (exp_v) begin
        chk("vram_address", 32'(vram_address), 32'(req_a[m_owner]));
        chk("vram_write", 32'(vram_write), 32'((m_owner >= 2) ? req_w[m_owner] : 1'b0));
        if (m_owner >= 2 && req_w[m_owner])
          chk("vram_wdata", 32'(vram_wdata), 32'(req_d[m_owner]));
      end else if (m_fresh) begin
        chk("idle_address", 32'(vram_address), 32'h0);
        chk("idle_write", 32'(vram_write), 32'h0);
        chk("idle_wdata", 32'(vram_wdata), 32'h0);
      end
      got_ready = exp_rdy;
      for (int x = 0; x < 4; x++) begin
        if (dut_ready[x]) ready_log.push_back(x);
        if (dut_rden[x]) begin rd_owner.push_back(x); rd_val.push_back(rdata); end
      end
    end
  end

  task automatic new_req(input int x);
    req_v[x] = 1'b1;
    req_a[x] = 17'($urandom);
    req_w[x] = (x >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    req_d[x] = 8'($urandom);
  endtask

  // Advance one cycle and apply requester/downstream behaviour
  task automatic step();
    @(posedge clk);
    #1;
    for (int x = 0; x < 4; x++) begin
      if (got_ready[x]) begin
        if (persist[x]) new_req(x);
        else req_v[x] = 1'b0;
      end
      if (rnd_req) begin
        if (!req_v[x] && $urandom_range(0, 3) == 0) new_req(x);
        else if (req_v[x] && !(m_busy && m_owner == x) && $urandom_range(0, 31) == 0) req_v[x] = 1'b0;
      end
    end
    if (ds_rand) begin
      vram_ready    = ($urandom_range(0, 9) < 7);
      vram_rdata_en = ($urandom_range(0, 9) < 4);
      vram_rdata    = $urandom;
    end else begin
      vram_ready    = 1'b1;
      vram_rdata_en = 1'b0;
      if (acc_read_now) pend = lat;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          vram_rdata_en = 1'b1;
          vram_rdata    = next_val;
          next_val      = next_val + 32'h11111111;
        end
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (req_v != 4'b0 || m_busy); i++) step();
  endtask

  int cyc, n0, cnt_cmd, cnt_cpu, repeats, cnt3;
  bit found;

  initial begin
    reset = 1'b1; req_v = '0; req_w = '0;
    for (int x = 0; x < 4; x++) begin req_a[x] = '0; req_d[x] = '0; end
    vram_ready = 1'b1; vram_rdata_en = 1'b0; vram_rdata = '0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_vram_valid", 32'(vram_valid), 32'h0);
    chk("rst_vram_address", 32'(vram_address), 32'h0);
    chk("rst_ready", 32'(dut_ready), 32'h0);
    chk("rst_rdata", rdata, 32'h0);

    // Single CPU write
    step();
    req_v[3] = 1'b1; req_a[3] = 17'h01E00; req_w[3] = 1'b1; req_d[3] = 8'h32;
    @(negedge clk);
    chk("wr_c0_cpu_ready", 32'(cpu_ready), 32'h0);
    chk("wr_c0_vram_valid", 32'(vram_valid), 32'h0);
    step(); @(negedge clk);
    chk("wr_c1_vram_valid", 32'(vram_valid), 32'h1);
    chk("wr_c1_address", 32'(vram_address), 32'h01E00);
    chk("wr_c1_write", 32'(vram_write), 32'h1);
    chk("wr_c1_wdata", 32'(vram_wdata), 32'h32);
    chk("wr_c1_cpu_ready", 32'(cpu_ready), 32'h1);
    step(); @(negedge clk);
    chk("wr_c2_vram_valid", 32'(vram_valid), 32'h0);
    chk("wr_c2_cpu_ready", 32'(cpu_ready), 32'h0);

    // All four read at once, latency 3
    ready_log.delete(); rd_owner.delete(); rd_val.delete();
    lat = 3; next_val = 32'h11111111;
    step();
    for (int x = 0; x < 4; x++) begin
      req_v[x] = 1'b1; req_w[x] = 1'b0; req_a[x] = 17'(32'h100 * (x + 1)); req_d[x] = '0;
    end
    for (int i = 0; i < 100 && rd_owner.size() < 4; i++) step();
    chk("all4_reads", 32'(rd_owner.size()), 32'd4);
    for (int i = 0; i < 4 && i < rd_owner.size(); i++) begin
      chk($sformatf("all4_owner%0d", i), 32'(rd_owner[i]), 32'(i));
      chk($sformatf("all4_data%0d", i), rd_val[i], 32'h11111111 * 32'(i + 1));
    end
    drain();

    // cmd and cpu continuously valid: strict alternation
    ready_log.delete(); lat = 1;
    step();
    persist[2] = 1'b1; persist[3] = 1'b1; new_req(2); new_req(3);
    for (int i = 0; i < 2000 && ready_log.size() < 100; i++) step();
    persist = '0;
    drain();
    cnt_cmd = 0; cnt_cpu = 0; repeats = 0;
    for (int i = 0; i < ready_log.size(); i++) begin
      if (ready_log[i] == 2) cnt_cmd++;
      if (ready_log[i] == 3) cnt_cpu++;
      if (i > 0 && ready_log[i] == ready_log[i-1]) repeats++;
    end
    chk("rr_enough_grants", 32'(ready_log.size() >= 100), 32'h1);
    chk("rr_first_is_cmd", 32'(ready_log.size() > 0 ? ready_log[0] : -1), 32'd2);
    chk("rr_repeats", 32'(repeats), 32'h0);
    chk("rr_balance", 32'(cnt_cmd - cnt_cpu <= 1 && cnt_cpu - cnt_cmd <= 1), 32'h1);

    // Sprite hogging the port: CPU promoted after CPU_MAX_WAIT
    step();
    persist[1] = 1'b1; new_req(1);
    repeat (4) step();
    req_v[3] = 1'b1; req_a[3] = 17'h1ABCD; req_w[3] = 1'b1; req_d[3] = 8'hA5;
    cyc = 0; found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cpu_ready) begin found = 1; break; end
      step(); cyc++;
    end
    chk("promo_granted", 32'(found), 32'h1);
    chk("promo_latency_window", 32'(cyc >= 33 && cyc <= 35), 32'h1);
    step(); step(); @(negedge clk);
    chk("promo_wait_cleared", 32'(dut.cpu_wait), 32'h0);
    persist = '0;
    drain();

    // Screen keeps winning over a promoted CPU
    ready_log.delete();
    step();
    persist[0] = 1'b1; new_req(0);
    step();
    req_v[3] = 1'b1; req_a[3] = 17'h00042; req_w[3] = 1'b0; req_d[3] = 8'h00;
    repeat (60) step();
    @(negedge clk);
    cnt3 = 0;
    foreach (ready_log[i]) if (ready_log[i] == 3) cnt3++;
    chk("scr_beats_promoted", 32'(cnt3), 32'h0);
    chk("scr_cpu_wait_sat", 32'(dut.cpu_wait), 32'(MAXW));
    persist = '0;
    for (int i = 0; i < 30; i++) begin
      step(); @(negedge clk);
      if (cpu_ready) break;
    end
    step();
    chk("scr_then_cpu_last", 32'(ready_log.size() > 1 ? ready_log[ready_log.size()-1] : -1), 32'd3);
    chk("scr_then_cpu_prev", 32'(ready_log.size() > 1 ? ready_log[ready_log.size()-2] : -1), 32'd0);
    drain();

    // Reset during WAIT_DATA, then late read data
    lat = 3;
    step();
    req_v[2] = 1'b1; req_a[2] = 17'h0BEEF; req_w[2] = 1'b0; req_d[2] = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
      step();
    end
    n0 = rd_owner.size();
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    step(); @(negedge clk);
    chk("rstwd_cmd_rdata_en", 32'(cmd_rdata_en), 32'h0);
    chk("rstwd_rdata", rdata, 32'h0);
    chk("rstwd_vram_valid", 32'(vram_valid), 32'h0);
    chk("rstwd_vram_address", 32'(vram_address), 32'h0);
    chk("rstwd_vram_wdata", 32'(vram_wdata), 32'h0);
    repeat (3) step();
    chk("rstwd_no_data", 32'(rd_owner.size()), 32'(n0));

    // Random traffic with random downstream and occasional reset
    rnd_req = 1; ds_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      step();
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
    step();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
